// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED pulse stretcher.
//   - led_state_e   : per-channel FSM state encoding (2 bits)
//   - LED_MODE_*    : retrigger mode values carried on i_mode
//   - gap_cnt_width : width of the off-gap counter for a given gap length
`timescale 1ns/1ps
package led_pkg;

    typedef enum logic [1:0] {
        LED_IDLE = 2'd0,
        LED_HOLD = 2'd1,
        LED_GAP  = 2'd2
    } led_state_e;

    localparam logic LED_MODE_IGNORE  = 1'b0;
    localparam logic LED_MODE_RESTART = 1'b1;

    // The gap counter only has to hold GAP_CYC-1 down to 0. It keeps at
    // least one bit so the register still exists when the gap is disabled.
    function automatic int gap_cnt_width(input int gap_cyc);
        return (gap_cyc <= 2) ? 1 : $clog2(gap_cyc);
    endfunction

endpackage

// File: rtl/led_pulse_stretcher_if.sv
// led_pulse_stretcher_if: groups the per-channel control and LED outputs
// of the pulse stretcher.
//   i_trigger  [N_CH]  : per-channel trigger
//   i_mode     [N_CH]  : per-channel retrigger mode (1 restart, 0 ignore)
//   i_hold_len [CNT_W] : shared hold length in cycles (0 behaves as 1)
//   i_duty     [PWM_W] : shared brightness
//   i_clear            : synchronous clear of all channels
//   o_active   [N_CH]  : channel is holding (not dimmed)
//   o_led      [N_CH]  : o_active gated by the PWM on-phase
// master drives the controls, slave is the stretcher itself.
`timescale 1ns/1ps
interface led_pulse_stretcher_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 24,
    parameter int PWM_W = 8
);
    logic [N_CH-1:0]  i_trigger;
    logic [N_CH-1:0]  i_mode;
    logic [CNT_W-1:0] i_hold_len;
    logic [PWM_W-1:0] i_duty;
    logic             i_clear;
    logic [N_CH-1:0]  o_active;
    logic [N_CH-1:0]  o_led;

    modport master (
        output i_trigger, i_mode, i_hold_len, i_duty, i_clear,
        input  o_active, o_led
    );

    modport slave (
        input  i_trigger, i_mode, i_hold_len, i_duty, i_clear,
        output o_active, o_led
    );
endinterface

// File: rtl/led_hold_channel.sv
// led_hold_channel: one stretcher channel. Turns a trigger into a hold of
// max(i_hold_len,1) cycles; a restart retrigger either reloads the hold
// directly (GAP_CYC=0) or inserts a GAP_CYC-cycle off-gap first.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_trigger        : trigger for this channel
//   i_mode           : retrigger mode, sampled with the trigger
//   i_hold_len       : hold length, latched when a trigger is taken
//   i_clear          : synchronous clear, beats any same-cycle trigger
//   o_active         : registered "in HOLD" flag
`timescale 1ns/1ps
module led_hold_channel
    import led_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int GAP_CYC = 0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_trigger,
    input  logic             i_mode,
    input  logic [CNT_W-1:0] i_hold_len,
    input  logic             i_clear,
    output logic             o_active
);
    localparam int GW = gap_cnt_width(GAP_CYC);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    led_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] hold_l;
    logic             restart;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= LED_IDLE;
            cnt_q    <= '0;
            gcnt_q   <= '0;
            len_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
            len_q    <= len_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        len_d   = len_q;
        // A zero length would underflow the countdown, so it is promoted to 1.
        hold_l  = (i_hold_len == '0) ? CNT_W'(1) : i_hold_len;
        restart = i_trigger && (i_mode == LED_MODE_RESTART);

        if (i_clear) begin
            state_d = LED_IDLE;
            cnt_d   = '0;
            gcnt_d  = '0;
        end else begin
            case (state_q)
                LED_IDLE: begin
                    if (i_trigger) begin
                        state_d = LED_HOLD;
                        cnt_d   = hold_l - CNT_W'(1);
                        len_d   = hold_l;
                    end
                end
                LED_HOLD: begin
                    // Checked before expiry so a retrigger on the last
                    // cycle extends the pulse instead of dropping it.
                    if (restart) begin
                        len_d = hold_l;
                        if (GAP_CYC == 0) begin
                            cnt_d = hold_l - CNT_W'(1);
                        end else begin
                            state_d = LED_GAP;
                            gcnt_d  = GAP_LOAD;
                        end
                    end else if (cnt_q == '0) begin
                        state_d = LED_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                LED_GAP: begin
                    if (gcnt_q == '0) begin
                        state_d = LED_HOLD;
                        cnt_d   = len_q - CNT_W'(1);
                    end else begin
                        gcnt_d = gcnt_q - GW'(1);
                    end
                end
                default: begin
                    state_d = LED_IDLE;
                end
            endcase
        end

        // Registered separately so o_active is a plain flop output.
        active_d = (state_d == LED_HOLD);
    end

    assign o_active = active_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: N_CH independent hold channels sharing one
// free-running PWM dimmer. Sits between the beat/accent generators and
// the board LED pins.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   bus (slave)      : triggers/modes/hold length/duty/clear in,
//                      o_active and PWM-gated o_led out
`timescale 1ns/1ps
module led_pulse_stretcher
    import led_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 24,
    parameter int GAP_CYC = 0,
    parameter int PWM_W   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    led_pulse_stretcher_if.slave  bus
);
    logic [N_CH-1:0]  active_w;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic             pwm_on_q, pwm_on_d;

    for (genvar gi = 0; gi < N_CH; gi++) begin : gen_ch
        led_hold_channel #(
            .CNT_W   (CNT_W),
            .GAP_CYC (GAP_CYC)
        ) u_ch (
            .i_clk      (i_clk),
            .i_reset_n  (i_reset_n),
            .i_trigger  (bus.i_trigger[gi]),
            .i_mode     (bus.i_mode[gi]),
            .i_hold_len (bus.i_hold_len),
            .i_clear    (bus.i_clear),
            .o_active   (active_w[gi])
        );
    end

    // The on-phase flag is computed against the next counter value so that
    // pwm_on_q always describes the pwm_cnt_q held alongside it. i_clear
    // deliberately leaves the PWM running.
    assign pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    assign pwm_on_d  = (bus.i_duty == '1) || (pwm_cnt_d < bus.i_duty);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pwm_cnt_q <= '0;
            pwm_on_q  <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            pwm_on_q  <= pwm_on_d;
        end
    end

    assign bus.o_active = active_w;
    assign bus.o_led    = active_w & {N_CH{pwm_on_q}};

endmodule
